matmul_tile_scheduler: RTL and testbench



---
 rtl/matmul_tile_scheduler.sv | 162 ++++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_scheduler.sv
// Job sequencer for one N x N systolic matmul: walks the C tile grid row-major,
// triggering the B loader, streaming A rows and waiting on the C gather unit.
module matmul_tile_scheduler #(
  parameter int N             = 16,
  parameter int W             = 8,
  parameter int BRAM_W        = 256,
  parameter int BRAM_AW       = 10,
  parameter int DATA_A_SIZE_Y = 64,
  parameter int DATA_B_SIZE_X = 64,
  parameter int DATA_B_SIZE_Y = 64,
  parameter int TIMEOUT       = 4096
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   abort,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic                                   ld_b_start,
  input  logic                                   ld_b_done,
  output logic                                   start_cal,
  output logic [$clog2(DATA_A_SIZE_Y)-1:0]       a_row_idx,
  input  logic                                   gather_done,
  output logic [$clog2(DATA_B_SIZE_Y/N)-1:0]     tile_row,
  output logic [$clog2(DATA_B_SIZE_X/N)-1:0]     tile_col,
  output logic [BRAM_AW-1:0]                     c_base_addr
);

  localparam int ROW_TILES = DATA_B_SIZE_Y / N;
  localparam int COL_TILES = DATA_B_SIZE_X / N;
  localparam int WPT       = DATA_A_SIZE_Y * N * 2 * W / BRAM_W;
  localparam int AW        = $clog2(DATA_A_SIZE_Y);
  localparam int RW        = $clog2(ROW_TILES);
  localparam int CW        = $clog2(COL_TILES);
  localparam int WDW       = $clog2(TIMEOUT);

  localparam logic [AW-1:0]  LAST_ROW_IDX = AW'(DATA_A_SIZE_Y - 1);
  localparam logic [RW-1:0]  LAST_TROW    = RW'(ROW_TILES - 1);
  localparam logic [CW-1:0]  LAST_TCOL    = CW'(COL_TILES - 1);
  localparam logic [WDW-1:0] LAST_WD      = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_B, WAIT_B, STREAM, WAIT_G, NEXT, DONE, ERR
  } state_t;

  state_t         state, state_n;
  logic [AW-1:0]  stream_cnt, stream_cnt_n;
  logic [WDW-1:0] wd_cnt, wd_cnt_n;
  logic [RW-1:0]  tile_row_n;
  logic [CW-1:0]  tile_col_n;
  logic           err_n;
  logic [31:0]    tile_lin, base_full;

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      stream_cnt <= '0;
      wd_cnt     <= '0;
      tile_row   <= '0;
      tile_col   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      stream_cnt <= stream_cnt_n;
      wd_cnt     <= wd_cnt_n;
      tile_row   <= tile_row_n;
      tile_col   <= tile_col_n;
      err        <= err_n;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold value first so no path through the
    // case below leaves one unassigned and infers a latch.
    state_n      = state;
    stream_cnt_n = stream_cnt;
    wd_cnt_n     = wd_cnt;
    tile_row_n   = tile_row;
    tile_col_n   = tile_col;
    err_n        = err;

    // Abort clears the walk but leaves a pending timeout flag visible.
    if (abort && state != IDLE) begin
      state_n      = IDLE;
      stream_cnt_n = '0;
      wd_cnt_n     = '0;
      tile_row_n   = '0;
      tile_col_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state_n    = LOAD_B;
            tile_row_n = '0;
            tile_col_n = '0;
            err_n      = 1'b0;
          end
        end
        LOAD_B: state_n = WAIT_B;
        WAIT_B: begin
          if (ld_b_done) begin
            state_n      = STREAM;
            stream_cnt_n = '0;
          end
        end
        STREAM: begin
          if (stream_cnt == LAST_ROW_IDX) begin
            state_n      = WAIT_G;
            stream_cnt_n = '0;
            wd_cnt_n     = '0;
          end else begin
            stream_cnt_n = stream_cnt + 1'b1;
          end
        end
        WAIT_G: begin
          // gather_done takes priority over an expiring watchdog.
          if (gather_done) begin
            state_n = NEXT;
          end else if (wd_cnt == LAST_WD) begin
            state_n = ERR;
            err_n   = 1'b1;
          end else begin
            wd_cnt_n = wd_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (tile_row == LAST_TROW && tile_col == LAST_TCOL) begin
            state_n = DONE;
          end else if (tile_col == LAST_TCOL) begin
            state_n    = LOAD_B;
            tile_col_n = '0;
            tile_row_n = tile_row + 1'b1;
          end else begin
            state_n    = LOAD_B;
            tile_col_n = tile_col + 1'b1;
          end
        end
        DONE:    state_n = IDLE;
        ERR:     state_n = ERR;
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy       = (state == LOAD_B) || (state == WAIT_B) || (state == STREAM) ||
                      (state == WAIT_G) || (state == NEXT)   || (state == DONE);
  assign done       = (state == DONE);
  assign ld_b_start = (state == LOAD_B);
  assign start_cal  = (state == STREAM);
  assign a_row_idx  = start_cal ? stream_cnt : '0;

  // Base address wraps modulo the BRAM depth.
  always_comb begin
    tile_lin  = 32'(tile_row) * 32'(COL_TILES) + 32'(tile_col);
    base_full = tile_lin * 32'(WPT);
  end
  assign c_base_addr = base_full[BRAM_AW-1:0];

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench for matmul_tile_scheduler: drives the loader/gather
// handshakes with random delays and checks against a tile-walk reference.
module tb_matmul_tile_scheduler;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int AROWS   = 64;
  localparam int WPT     = 64;
  localparam int BAW     = 10;
  localparam int TO      = 32;

  logic       clk = 1'b0;
  logic       rst, start, abort, ld_b_done, gather_done;
  logic       busy, done, err, ld_b_start, start_cal;
  logic [5:0] a_row_idx;
  logic [1:0] tile_row, tile_col;
  logic [9:0] c_base_addr;

  int vectors     = 0;
  int miscompares = 0;

  matmul_tile_scheduler #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ld_b_start  (ld_b_start),
    .ld_b_done   (ld_b_done),
    .start_cal   (start_cal),
    .a_row_idx   (a_row_idx),
    .gather_done (gather_done),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .c_base_addr (c_base_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int r, input int c);
    return ((r * COLS + c) * WPT) % (1 << BAW);
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_start_cal"}, start_cal, 0);
    chk({tag, "_ld_b_start"}, ld_b_start, 0);
    chk({tag, "_a_row_idx"}, a_row_idx, 0);
    chk({tag, "_tile_row"}, tile_row, 0);
    chk({tag, "_tile_col"}, tile_col, 0);
    chk({tag, "_c_base_addr"}, c_base_addr, 0);
  endtask

  // Entered in the ld_b_start cycle; leaves in the first streaming cycle.
  task automatic load_phase(input int r, input int c, input int ldb_delay, input bit spur);
    chk("ld_b_start_hi", ld_b_start, 1);
    chk("busy_load", busy, 1);
    chk("tile_row_load", tile_row, r);
    chk("tile_col_load", tile_col, c);
    chk("c_base_addr", c_base_addr, exp_addr(r, c));
    chk("start_cal_load", start_cal, 0);
    if (spur) ld_b_done = 1'b1;
    tick();
    ld_b_done = 1'b0;
    for (int d = 1; d < ldb_delay; d++) begin
      chk("ld_b_start_pulse", ld_b_start, 0);
      chk("start_cal_wait_b", start_cal, 0);
      tick();
    end
    chk("ld_b_start_pulse", ld_b_start, 0);
    ld_b_done = 1'b1;
    tick();
    ld_b_done = 1'b0;
  endtask

  // Leaves in the first WAIT_G cycle, or in the cycle after an abort.
  task automatic stream_phase(input int r, input int c, input bit spur, input int abort_at);
    bit aborted = 1'b0;
    for (int i = 0; i < AROWS && !aborted; i++) begin
      chk("start_cal_burst", start_cal, 1);
      chk("a_row_idx", a_row_idx, i);
      chk("tile_row_stream", tile_row, r);
      chk("tile_col_stream", tile_col, c);
      chk("done_stream", done, 0);
      if (spur && i == 10) gather_done = 1'b1;
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("start_cal_after_abort", start_cal, 0);
        chk("busy_after_abort", busy, 0);
        chk("done_after_abort", done, 0);
        chk("tile_row_after_abort", tile_row, 0);
        chk("tile_col_after_abort", tile_col, 0);
        aborted = 1'b1;
      end else begin
        tick();
        gather_done = 1'b0;
      end
    end
    if (!aborted) begin
      chk("start_cal_fall", start_cal, 0);
      chk("a_row_idx_idle", a_row_idx, 0);
      chk("busy_wait_g", busy, 1);
    end
  endtask

  // Leaves in the cycle after NEXT (next ld_b_start, or the done pulse).
  task automatic gather_phase(input int g_delay, input bit spur);
    for (int d = 0; d < g_delay; d++) begin
      chk("busy_wait_g", busy, 1);
      chk("err_wait_g", err, 0);
      chk("start_cal_wait_g", start_cal, 0);
      if (spur && d == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    gather_done = 1'b1;
    tick();
    gather_done = 1'b0;
    chk("err_next", err, 0);
    chk("busy_next", busy, 1);
    chk("ld_b_start_next", ld_b_start, 0);
    chk("done_next", done, 0);
    tick();
  endtask

  // ldb/g below zero pick random delays; spur adds ignored stray inputs.
  task automatic run_job(input int ldb, input int g, input bit spur);
    int ld, gd;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        ld = (ldb < 0) ? int'($urandom_range(1, 6)) : ldb;
        gd = (g < 0) ? int'($urandom_range(0, TO - 1)) : g;
        if (spur && r == 1 && c == 1) gd = TO - 1;
        load_phase(r, c, ld, spur);
        stream_phase(r, c, spur, -1);
        gather_phase(gd, spur);
      end
    end
    chk("done_pulse", done, 1);
    chk("busy_on_done", busy, 1);
    chk("ld_b_start_on_done", ld_b_start, 0);
    tick();
    chk("done_single", done, 0);
    chk("busy_after_done", busy, 0);
    chk("err_after_job", err, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ld_b_done = 1'b0; gather_done = 1'b0;
    repeat (3) tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();

    // Reset during streaming.
    start = 1'b1;
    tick();
    start = 1'b0;
    load_phase(0, 0, 2, 1'b0);
    repeat (5) tick();
    chk("start_cal_pre_rst", start_cal, 1);
    rst = 1'b1;
    repeat (3) tick();
    chk_idle_zero("mid_rst");
    rst = 1'b0;
    tick();
    chk_idle_zero("post_rst");

    // Full job with fixed handshake delays.
    run_job(3, 10, 1'b0);
    repeat (2) tick();

    // Abort part way through tile (1,2).
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r < 1 || (r == 1 && c <= 2)) begin
          load_phase(r, c, int'($urandom_range(1, 6)), 1'b0);
          if (r == 1 && c == 2) begin
            stream_phase(r, c, 1'b0, 20);
          end else begin
            stream_phase(r, c, 1'b0, -1);
            gather_phase(int'($urandom_range(0, TO - 1)), 1'b0);
          end
        end
      end
    end
    repeat (4) begin
      chk("done_quiet_after_abort", done, 0);
      chk("busy_quiet_after_abort", busy, 0);
      tick();
    end

    // Restart from (0,0) with random delays and stray inputs.
    run_job(-1, -1, 1'b1);
    tick();

    // Gather timeout into ERR.
    start = 1'b1;
    tick();
    start = 1'b0;
    load_phase(0, 0, int'($urandom_range(1, 6)), 1'b0);
    stream_phase(0, 0, 1'b0, -1);
    for (int d = 0; d < TO; d++) begin
      chk("err_before_timeout", err, 0);
      chk("busy_before_timeout", busy, 1);
      tick();
    end
    chk("err_timeout", err, 1);
    chk("busy_timeout", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_start_ignored", err, 1);
    chk("ld_b_start_in_err", ld_b_start, 0);
    chk("busy_in_err", busy, 0);
    tick();
    chk("ld_b_start_in_err2", ld_b_start, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("err_after_abort", err, 1);
    chk("busy_after_err_abort", busy, 0);
    tick();
    chk("err_idle_sticky", err, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared_by_start", err, 0);
    chk("ld_b_start_restart", ld_b_start, 1);
    chk("c_base_addr_restart", c_base_addr, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("busy_final_abort", busy, 0);
    chk("err_final", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
